// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter and its per-source queues.
package wb_arbiter_pkg;

    localparam int WB_NSRC_DEFAULT = 3;
    localparam int WB_XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [4:0]                 rd_addr;
        logic [WB_XLEN_DEFAULT-1:0] rd_data;
    } wb_entry_t;

    // Next round-robin start after granting ptr; the range is lo..n-1.
    function automatic int rr_next(input int ptr, input int n, input int lo = 0);
        return (ptr + 1 >= n) ? lo : ptr + 1;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source writeback queue; pointers wrap naturally, full/empty come from count.
// Exposes per-entry valid/rd so the top can build the pending-destination bitmap.
module wb_src_fifo
    import wb_arbiter_pkg::*;
#(
    parameter  int XLEN   = WB_XLEN_DEFAULT,
    parameter  int QDEPTH = 2,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    input  logic [4:0]           push_rd_i,
    input  logic [XLEN-1:0]      push_data_i,
    output logic [CW-1:0]        count_o,
    output logic [4:0]           head_rd_o,
    output logic [XLEN-1:0]      head_data_o,
    output logic [QDEPTH-1:0]    ent_vld_o,
    output logic [QDEPTH*5-1:0]  ent_rd_o
);

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_data;
    } entry_t;

    entry_t        mem_q [QDEPTH];
    entry_t        mem_d [QDEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] off;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q] = '{rd_addr: push_rd_i, rd_data: push_data_i};
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop_i)
                rptr_d = rptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < QDEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        off       = '0;
        ent_vld_o = '0;
        ent_rd_o  = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            off                 = AW'(i) - rptr_q;
            ent_vld_o[i]        = CW'(off) < cnt_q;
            ent_rd_o[5*i +: 5]  = mem_q[i].rd_addr;
        end
    end

    assign count_o     = cnt_q;
    assign head_rd_o   = mem_q[rptr_q].rd_addr;
    assign head_data_o = mem_q[rptr_q].rd_data;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source queues, one registered register-file write per cycle.
// Source 0 optionally has strict priority; the rest share a round-robin pointer.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_SRC  = WB_NSRC_DEFAULT,
    parameter int XLEN   = WB_XLEN_DEFAULT,
    parameter int QDEPTH = 2,
    parameter int PRIO0  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      i_src_valid,
    input  logic [N_SRC*5-1:0]    i_src_rd_addr,
    input  logic [N_SRC*XLEN-1:0] i_src_rd_data,
    output logic [N_SRC-1:0]      o_src_ready,
    input  logic [N_SRC-1:0]      i_flush,
    output logic                  o_wb_wren,
    output logic [4:0]            o_wb_rd_addr,
    output logic [XLEN-1:0]       o_wb_rd_data,
    output logic [31:0]           o_pending_rd,
    output logic                  o_err
);

    localparam int CW   = $clog2(QDEPTH + 1);
    localparam int LO   = (PRIO0 != 0 && N_SRC > 1) ? 1 : 0;
    localparam int RR_N = N_SRC - LO;
    localparam int PW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [CW-1:0]        cnt       [N_SRC];
    logic [4:0]           head_rd   [N_SRC];
    logic [XLEN-1:0]      head_data [N_SRC];
    logic [QDEPTH-1:0]    ent_vld   [N_SRC];
    logic [QDEPTH*5-1:0]  ent_rd    [N_SRC];
    logic [N_SRC-1:0]     push, pop, cand;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign o_src_ready[k] = (cnt[k] != CW'(QDEPTH));
        // rd==0 completes the handshake but never occupies a slot
        assign push[k] = i_src_valid[k] & o_src_ready[k] & ~i_flush[k]
                       & (i_src_rd_addr[5*k +: 5] != 5'd0);
        assign cand[k] = (cnt[k] != '0) & ~i_flush[k];

        wb_src_fifo #(.XLEN(XLEN), .QDEPTH(QDEPTH)) u_fifo (
            .clk_i       (clk_i),
            .rst         (rst),
            .push_i      (push[k]),
            .pop_i       (pop[k]),
            .flush_i     (i_flush[k]),
            .push_rd_i   (i_src_rd_addr[5*k +: 5]),
            .push_data_i (i_src_rd_data[XLEN*k +: XLEN]),
            .count_o     (cnt[k]),
            .head_rd_o   (head_rd[k]),
            .head_data_o (head_data[k]),
            .ent_vld_o   (ent_vld[k]),
            .ent_rd_o    (ent_rd[k])
        );
    end

    logic [PW-1:0]   rr_q, rr_d;
    logic            found;
    int              idx;
    logic            wb_wren_q, wb_wren_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;
    logic [31:0]     pend;

    always_comb begin
        pop   = '0;
        rr_d  = rr_q;
        found = 1'b0;
        idx   = 0;
        if (PRIO0 != 0 && cand[0]) begin
            pop[0] = 1'b1;
        end else begin
            for (int j = 0; j < RR_N; j++) begin
                idx = LO + ((int'(rr_q) - LO + j) % RR_N);
                for (int k = LO; k < N_SRC; k++) begin
                    if (!found && k == idx && cand[k]) begin
                        found  = 1'b1;
                        pop[k] = 1'b1;
                        rr_d   = PW'(rr_next(k, N_SRC, LO));
                    end
                end
            end
        end
    end

    always_comb begin
        wb_wren_d = |pop;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        for (int k = 0; k < N_SRC; k++) begin
            if (pop[k]) begin
                wb_addr_d = head_rd[k];
                wb_data_d = head_data[k];
            end
        end
        err_d = err_q | (|(i_src_valid & ~o_src_ready));
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            rr_q      <= PW'(LO);
            wb_wren_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            wb_wren_q <= wb_wren_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    // The in-flight register-file write still counts as pending for hazards.
    always_comb begin
        pend = '0;
        for (int k = 0; k < N_SRC; k++)
            for (int e = 0; e < QDEPTH; e++)
                if (ent_vld[k][e])
                    pend[ent_rd[k][5*e +: 5]] = 1'b1;
        if (wb_wren_q)
            pend[wb_addr_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign o_pending_rd = pend;
    assign o_wb_wren    = wb_wren_q;
    assign o_wb_rd_addr = wb_addr_q;
    assign o_wb_rd_data = wb_data_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one PRIO0=1 instance plus a PRIO0=0 instance on shared stimulus.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst;
    logic [2:0]  valid, flush;
    logic [14:0] rd_bus;
    logic [95:0] data_bus;

    logic [2:0]  rdy,   rdy_b;
    logic        wren,  wren_b;
    logic [4:0]  waddr, waddr_b;
    logic [31:0] wdata, wdata_b;
    logic [31:0] pend,  pend_b;
    logic        err,   err_b;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.N_SRC(3), .XLEN(32), .QDEPTH(2), .PRIO0(1)) u_dut (
        .clk_i(clk_i), .rst(rst), .i_src_valid(valid), .i_src_rd_addr(rd_bus),
        .i_src_rd_data(data_bus), .o_src_ready(rdy), .i_flush(flush),
        .o_wb_wren(wren), .o_wb_rd_addr(waddr), .o_wb_rd_data(wdata),
        .o_pending_rd(pend), .o_err(err)
    );

    wb_arbiter #(.N_SRC(3), .XLEN(32), .QDEPTH(2), .PRIO0(0)) u_dut_rr (
        .clk_i(clk_i), .rst(rst), .i_src_valid(valid), .i_src_rd_addr(rd_bus),
        .i_src_rd_data(data_bus), .o_src_ready(rdy_b), .i_flush(flush),
        .o_wb_wren(wren_b), .o_wb_rd_addr(waddr_b), .o_wb_rd_data(wdata_b),
        .o_pending_rd(pend_b), .o_err(err_b)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_in;
        valid = '0;
        flush = '0;
    endtask

    task automatic set_src(input int k, input logic [4:0] rd, input logic [31:0] d);
        valid[k]          = 1'b1;
        rd_bus[5*k +: 5]  = rd;
        data_bus[32*k +: 32] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_in();
        rd_bus = '0;
        data_bus = '0;
        tick();
        tick();
        tests_run++;
        if (wren !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            fails++; $display("FAIL reset_wb: wren=%b rd=%0d data=%h, want 0/0/0", wren, waddr, wdata);
        end
        tests_run++;
        if (pend !== 32'd0 || err !== 1'b0 || rdy !== 3'b111) begin
            fails++; $display("FAIL reset_state: pend=%h err=%b rdy=%b, want 0/0/111", pend, err, rdy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_collision;
        set_src(0, 5'd1, 32'h11);
        set_src(1, 5'd2, 32'h22);
        set_src(2, 5'd3, 32'h33);
        tick();
        clear_in();
        tests_run++;
        if (wren !== 1'b0 || pend !== 32'h0000_000E) begin
            fails++; $display("FAIL coll_queued: wren=%b pend=%h, want 0/0000000e", wren, pend);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd1 || wdata !== 32'h11) begin
            fails++; $display("FAIL coll_wb0: wren=%b rd=%0d data=%h, want 1/1/11", wren, waddr, wdata);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd2 || wdata !== 32'h22) begin
            fails++; $display("FAIL coll_wb1: wren=%b rd=%0d data=%h, want 1/2/22", wren, waddr, wdata);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33) begin
            fails++; $display("FAIL coll_wb2: wren=%b rd=%0d data=%h, want 1/3/33", wren, waddr, wdata);
        end
        set_src(1, 5'd12, 32'hC);
        set_src(2, 5'd13, 32'hD);
        tick();
        clear_in();
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd12) begin
            fails++; $display("FAIL rr_first: wren=%b rd=%0d, want 1/12", wren, waddr);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd13 || err !== 1'b0) begin
            fails++; $display("FAIL rr_second: wren=%b rd=%0d err=%b, want 1/13/0", wren, waddr, err);
        end
        tick();
    endtask

    task automatic test_single;
        set_src(1, 5'd5, 32'hDEADBEEF);
        tick();
        clear_in();
        tests_run++;
        if (wren !== 1'b0 || pend[5] !== 1'b1) begin
            fails++; $display("FAIL single_queued: wren=%b pend5=%b, want 0/1", wren, pend[5]);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF || pend[5] !== 1'b1) begin
            fails++; $display("FAIL single_wb: wren=%b rd=%0d data=%h pend5=%b, want 1/5/deadbeef/1", wren, waddr, wdata, pend[5]);
        end
        tick();
        tests_run++;
        if (wren !== 1'b0 || pend[5] !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_idle: wren=%b pend5=%b rd=%0d data=%h, want 0/0/5/deadbeef", wren, pend[5], waddr, wdata);
        end
    endtask

    task automatic test_full;
        set_src(0, 5'd20, 32'h100);
        set_src(2, 5'd10, 32'hA10);
        tick();
        tests_run++;
        if (rdy[2] !== 1'b1 || err !== 1'b0) begin
            fails++; $display("FAIL full_one: rdy2=%b err=%b, want 1/0", rdy[2], err);
        end
        set_src(0, 5'd21, 32'h101);
        set_src(2, 5'd11, 32'hA11);
        tick();
        tests_run++;
        if (rdy[2] !== 1'b0 || wren !== 1'b1 || waddr !== 5'd20 || err !== 1'b0) begin
            fails++; $display("FAIL full_two: rdy2=%b wren=%b rd=%0d err=%b, want 0/1/20/0", rdy[2], wren, waddr, err);
        end
        set_src(0, 5'd22, 32'h102);
        set_src(2, 5'd12, 32'hA12);
        tick();
        clear_in();
        tests_run++;
        if (err !== 1'b1 || rdy[2] !== 1'b0 || waddr !== 5'd21) begin
            fails++; $display("FAIL full_overflow: err=%b rdy2=%b rd=%0d, want 1/0/21", err, rdy[2], waddr);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd22 || wdata !== 32'h102) begin
            fails++; $display("FAIL full_src0_last: wren=%b rd=%0d data=%h, want 1/22/102", wren, waddr, wdata);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd10 || wdata !== 32'hA10 || rdy[2] !== 1'b1) begin
            fails++; $display("FAIL full_drain0: wren=%b rd=%0d data=%h rdy2=%b, want 1/10/a10/1", wren, waddr, wdata, rdy[2]);
        end
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd11 || wdata !== 32'hA11) begin
            fails++; $display("FAIL full_drain1: wren=%b rd=%0d data=%h, want 1/11/a11", wren, waddr, wdata);
        end
        tick();
        tests_run++;
        if (wren !== 1'b0 || pend !== 32'd0 || err !== 1'b1) begin
            fails++; $display("FAIL full_dropped: wren=%b pend=%h err=%b, want 0/0/1", wren, pend, err);
        end
    endtask

    task automatic test_flush;
        set_src(0, 5'd25, 32'h250);
        set_src(2, 5'd7, 32'h70);
        tick();
        set_src(0, 5'd26, 32'h260);
        set_src(2, 5'd8, 32'h80);
        tick();
        clear_in();
        tests_run++;
        if (pend[7] !== 1'b1 || pend[8] !== 1'b1 || waddr !== 5'd25) begin
            fails++; $display("FAIL flush_held: pend7=%b pend8=%b rd=%0d, want 1/1/25", pend[7], pend[8], waddr);
        end
        flush[2] = 1'b1;
        set_src(2, 5'd9, 32'h90);
        tick();
        clear_in();
        tests_run++;
        if (pend[9:7] !== 3'b000 || rdy[2] !== 1'b1 || wren !== 1'b1 || waddr !== 5'd26) begin
            fails++; $display("FAIL flush_empty: pend97=%b rdy2=%b wren=%b rd=%0d, want 000/1/1/26", pend[9:7], rdy[2], wren, waddr);
        end
        tick();
        tests_run++;
        if (wren !== 1'b0) begin
            fails++; $display("FAIL flush_nowrite: wren=%b rd=%0d, want wren 0", wren, waddr);
        end
        set_src(2, 5'd9, 32'h90);
        tick();
        clear_in();
        tests_run++;
        if (pend[9] !== 1'b1) begin
            fails++; $display("FAIL flush_refill: pend9=%b, want 1", pend[9]);
        end
        flush[2] = 1'b1;
        set_src(2, 5'd14, 32'hE0);
        tick();
        clear_in();
        tests_run++;
        if (wren !== 1'b0 || pend !== 32'd0) begin
            fails++; $display("FAIL flush_excluded: wren=%b rd=%0d pend=%h, want 0/-/0", wren, waddr, pend);
        end
        tick();
        tests_run++;
        if (wren !== 1'b0 || err !== 1'b1) begin
            fails++; $display("FAIL flush_after: wren=%b err=%b, want 0/1", wren, err);
        end
    endtask

    task automatic test_x0_wrap;
        set_src(1, 5'd0, 32'hBAD0);
        tick();
        clear_in();
        tests_run++;
        if (rdy[1] !== 1'b1 || pend !== 32'd0) begin
            fails++; $display("FAIL x0_accept: rdy1=%b pend=%h, want 1/0", rdy[1], pend);
        end
        tick();
        tests_run++;
        if (wren !== 1'b0) begin
            fails++; $display("FAIL x0_nowrite: wren=%b rd=%0d, want wren 0", wren, waddr);
        end
        for (int i = 0; i < 6; i++) begin
            set_src(1, 5'(16 + i), 32'hA000_0000 + i);
            tick();
            if (i > 0) begin
                tests_run++;
                if (wren !== 1'b1 || waddr !== 5'(15 + i) || wdata !== 32'hA000_0000 + i - 1 || rdy[1] !== 1'b1) begin
                    fails++; $display("FAIL wrap_%0d: wren=%b rd=%0d data=%h rdy1=%b, want 1/%0d/%h/1", i, wren, waddr, wdata, rdy[1], 15 + i, 32'hA000_0000 + i - 1);
                end
            end
        end
        clear_in();
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd21 || wdata !== 32'hA000_0005) begin
            fails++; $display("FAIL wrap_last: wren=%b rd=%0d data=%h, want 1/21/a0000005", wren, waddr, wdata);
        end
        tick();
        tests_run++;
        if (wren !== 1'b0 || pend !== 32'd0) begin
            fails++; $display("FAIL wrap_idle: wren=%b pend=%h, want 0/0", wren, pend);
        end
    endtask

    task automatic test_reset_mid;
        set_src(0, 5'd3, 32'h3);
        set_src(1, 5'd4, 32'h4);
        set_src(2, 5'd5, 32'h5);
        tick();
        clear_in();
        tick();
        tests_run++;
        if (wren !== 1'b1 || waddr !== 5'd3) begin
            fails++; $display("FAIL mid_before: wren=%b rd=%0d, want 1/3", wren, waddr);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (wren !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0 || pend !== 32'd0 || err !== 1'b0 || rdy !== 3'b111) begin
            fails++; $display("FAIL mid_async: wren=%b rd=%0d data=%h pend=%h err=%b rdy=%b, want all 0, rdy 111", wren, waddr, wdata, pend, err, rdy);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (wren !== 1'b0 || pend !== 32'd0) begin
            fails++; $display("FAIL mid_after: wren=%b pend=%h, want 0/0", wren, pend);
        end
    endtask

    task automatic test_rr_rotate;
        logic [4:0] exp_p [6];
        logic [4:0] exp_r [6];
        exp_p = '{5'd1, 5'd4, 5'd2, 5'd3, 5'd5, 5'd6};
        exp_r = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        for (int k = 0; k < 3; k++) set_src(k, 5'(1 + k), 32'h10 * (1 + k));
        tick();
        for (int k = 0; k < 3; k++) set_src(k, 5'(4 + k), 32'h10 * (4 + k));
        tick();
        clear_in();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            tests_run++;
            if (wren_b !== 1'b1 || waddr_b !== exp_r[i]) begin
                fails++; $display("FAIL rr_all_%0d: wren=%b rd=%0d, want 1/%0d", i, wren_b, waddr_b, exp_r[i]);
            end
            tests_run++;
            if (wren !== 1'b1 || waddr !== exp_p[i]) begin
                fails++; $display("FAIL prio_%0d: wren=%b rd=%0d, want 1/%0d", i, wren, waddr, exp_p[i]);
            end
        end
        tick();
        tests_run++;
        if (wren_b !== 1'b0 || wren !== 1'b0) begin
            fails++; $display("FAIL rr_idle: wren_rr=%b wren=%b, want 0/0", wren_b, wren);
        end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_single();
        test_full();
        test_flush();
        test_x0_wrap();
        test_reset_mid();
        test_rr_rotate();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
